// File: rtl/elastic_pipe_buffer.sv
// Purpose: DEPTH-entry in-order pipeline buffer with valid/ready on both sides, synchronous flush, occupancy count.
// Latency: 1 cycle from an accepted word to out_valid/out_data when empty; no same-cycle bypass.
// Backpressure: in_ready = not full, from registered state only; out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, reset      rising-edge clock; asynchronous active-high reset clears pointers, count and storage
//   flush           synchronous squash; empties the buffer at the next edge, overriding any push/pop
//   in_valid/in_ready/in_data      producer handshake; a word is taken when both valid and ready are high
//   out_valid/out_ready/out_data   consumer handshake; out_data is the oldest word, forced to 0 when empty
//   count           number of stored words, 0..DEPTH
module elastic_pipe_buffer #(
  parameter int  WIDTH = 24,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // A single-entry buffer still needs a 1-bit pointer; it simply never leaves 0.
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push, pop;

  // Handshake outputs depend only on count_q, so there is no input-to-output path.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Stale entries survive a flush; the zero gate keeps them invisible.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A word offered during a flush is dropped, so it is not written either.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_elastic_pipe_buffer.sv
module tb_elastic_pipe_buffer;

  logic        clk;
  logic        reset;

  // DEPTH=2 instance
  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [23:0] a_in_data, a_out_data;
  logic [1:0]  a_count;

  // DEPTH=3 instance
  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [23:0] b_in_data, b_out_data;
  logic [1:0]  b_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Model contents (accepted, not yet popped), and paired observed/expected output words.
  logic [23:0] a_exp[$], a_obs[$], a_ref[$];
  logic [23:0] b_exp[$], b_obs[$], b_ref[$];

  elastic_pipe_buffer #(.WIDTH(24), .DEPTH(2)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  elastic_pipe_buffer #(.WIDTH(24), .DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .count(b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  // Scoreboard monitors: sample handshakes mid-cycle, update the model for the coming edge.
  always @(negedge clk) begin
    if (reset || a_flush) begin
      a_exp.delete();
    end else begin
      if (a_out_valid && a_out_ready) begin
        a_obs.push_back(a_out_data);
        if (a_exp.size() > 0) a_ref.push_back(a_exp.pop_front());
        else                  a_ref.push_back(24'hxxxxxx);
      end
      if (a_in_valid && a_in_ready) a_exp.push_back(a_in_data);
    end
  end

  always @(negedge clk) begin
    if (reset || b_flush) begin
      b_exp.delete();
    end else begin
      if (b_out_valid && b_out_ready) begin
        b_obs.push_back(b_out_data);
        if (b_exp.size() > 0) b_ref.push_back(b_exp.pop_front());
        else                  b_ref.push_back(24'hxxxxxx);
      end
      if (b_in_valid && b_in_ready) b_exp.push_back(b_in_data);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle;
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
  endtask

  task automatic test_reset;
    logic [23:0] o, r;
    reset = 1; a_idle();
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    tick(); tick();
    n_tests++; if (a_count !== 2'd0)   begin n_fail++; $display("FAIL reset_count got=%0d want=0", a_count); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
    n_tests++; if (a_in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
    n_tests++; if (b_count !== 2'd0)   begin n_fail++; $display("FAIL reset_b_count got=%0d want=0", b_count); end
    reset = 0;
    tick();
    // Store two words, then reset asynchronously mid-cycle.
    a_in_valid = 1; a_in_data = 24'h111111; tick();
    a_in_data = 24'h222222; tick();
    a_in_valid = 0;
    n_tests++; if (a_count !== 2'd2) begin n_fail++; $display("FAIL pre_reset_count got=%0d want=2", a_count); end
    #2 reset = 1;
    #1;
    n_tests++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL async_reset_count got=%0d want=0", a_count); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_out_valid got=%b want=0", a_out_valid); end
    n_tests++; if (a_out_data !== 24'h000000) begin n_fail++; $display("FAIL async_reset_out_data got=%h want=000000", a_out_data); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL async_reset_in_ready got=%b want=1", a_in_ready); end
    tick();
    reset = 0;
    // First cycle after release must accept a word.
    a_in_valid = 1; a_in_data = 24'h333333; tick();
    a_in_valid = 0;
    n_tests++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL post_release_count got=%0d want=1", a_count); end
    n_tests++; if (a_out_data !== 24'h333333) begin n_fail++; $display("FAIL post_release_data got=%h want=333333", a_out_data); end
    a_out_ready = 1; tick(); a_out_ready = 0;
    n_tests++; if (a_obs.size() !== 1) begin n_fail++; $display("FAIL reset_drain_words got=%0d want=1", a_obs.size()); end
    while (a_obs.size() > 0 && a_ref.size() > 0) begin
      o = a_obs.pop_front(); r = a_ref.pop_front();
      n_tests++; if (o !== r) begin n_fail++; $display("FAIL reset_order got=%h want=%h", o, r); end
    end
  endtask

  task automatic test_fill_backpressure;
    logic [23:0] o, r;
    a_idle();
    a_in_valid = 1; a_in_data = 24'hA00001; tick();
    n_tests++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL fill_count1 got=%0d want=1", a_count); end
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready1 got=%b want=1", a_in_ready); end
    a_in_data = 24'hA00002; tick();
    n_tests++; if (a_count !== 2'd2) begin n_fail++; $display("FAIL fill_count2 got=%0d want=2", a_count); end
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready2 got=%b want=0", a_in_ready); end
    a_in_data = 24'hA00003; tick(); tick();
    n_tests++; if (a_count !== 2'd2) begin n_fail++; $display("FAIL fill_count_hold got=%0d want=2", a_count); end
    n_tests++; if (a_out_data !== 24'hA00001) begin n_fail++; $display("FAIL fill_head got=%h want=a00001", a_out_data); end
    a_in_valid = 0; a_out_ready = 1;
    tick(); tick();
    a_out_ready = 0;
    n_tests++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL fill_drained_count got=%0d want=0", a_count); end
    n_tests++; if (a_obs.size() !== 2) begin n_fail++; $display("FAIL fill_drain_words got=%0d want=2", a_obs.size()); end
    while (a_obs.size() > 0 && a_ref.size() > 0) begin
      o = a_obs.pop_front(); r = a_ref.pop_front();
      n_tests++; if (o !== r) begin n_fail++; $display("FAIL fill_order got=%h want=%h", o, r); end
    end
  endtask

  task automatic test_streaming;
    logic [23:0] o, r;
    a_idle();
    a_in_valid = 1; a_out_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      a_in_data = 24'(i);
      tick();
      n_tests++; if (a_out_data !== 24'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got=%h want=%h", i, a_out_data, 24'(i)); end
      n_tests++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d] got=%0d want=1", i, a_count); end
    end
    a_in_valid = 0; tick();
    a_out_ready = 0;
    n_tests++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL stream_end_count got=%0d want=0", a_count); end
    n_tests++; if (a_obs.size() !== 16) begin n_fail++; $display("FAIL stream_words got=%0d want=16", a_obs.size()); end
    while (a_obs.size() > 0 && a_ref.size() > 0) begin
      o = a_obs.pop_front(); r = a_ref.pop_front();
      n_tests++; if (o !== r) begin n_fail++; $display("FAIL stream_order got=%h want=%h", o, r); end
    end
  endtask

  task automatic test_wrap_depth3;
    logic [23:0] o, r, head;
    int next = 0;
    int cyc  = 0;
    logic acc;
    b_flush = 0;
    while ((next < 10 || b_exp.size() > 0) && cyc < 300) begin
      b_in_valid  = (next < 10) && ($urandom_range(0, 3) != 0);
      b_in_data   = 24'hC00000 + 24'(next);
      b_out_ready = (next >= 10) || ($urandom_range(0, 2) == 0);
      acc = b_in_valid && b_in_ready;
      tick();
      if (acc) next++;
      cyc++;
      head = (b_exp.size() > 0) ? b_exp[0] : 24'h000000;
      n_tests++; if (int'(b_count) !== b_exp.size() || b_count > 2'd3) begin n_fail++; $display("FAIL wrap_count got=%0d want=%0d", b_count, b_exp.size()); end
      n_tests++; if (b_out_data !== head) begin n_fail++; $display("FAIL wrap_head got=%h want=%h", b_out_data, head); end
      n_tests++; if (b_in_ready !== (b_exp.size() != 3)) begin n_fail++; $display("FAIL wrap_in_ready got=%b want=%b", b_in_ready, b_exp.size() != 3); end
    end
    b_in_valid = 0; b_out_ready = 0;
    n_tests++; if (cyc >= 300) begin n_fail++; $display("FAIL wrap_timeout got=%0d cycles want<300", cyc); end
    n_tests++; if (b_obs.size() !== 10) begin n_fail++; $display("FAIL wrap_words got=%0d want=10", b_obs.size()); end
    for (int k = 0; b_obs.size() > 0 && b_ref.size() > 0; k++) begin
      o = b_obs.pop_front(); r = b_ref.pop_front();
      n_tests++; if (o !== r || o !== 24'hC00000 + 24'(k)) begin n_fail++; $display("FAIL wrap_order[%0d] got=%h want=%h", k, o, 24'hC00000 + 24'(k)); end
    end
  endtask

  task automatic test_flush_priority;
    logic [23:0] o, r;
    a_idle();
    a_in_valid = 1; a_in_data = 24'h000005; tick();
    a_in_data = 24'h000006; tick();
    n_tests++; if (a_count !== 2'd2) begin n_fail++; $display("FAIL flush_pre_count got=%0d want=2", a_count); end
    a_flush = 1; a_in_valid = 1; a_in_data = 24'hBEEF00; a_out_ready = 1;
    tick();
    a_idle();
    n_tests++; if (a_count !== 2'd0) begin n_fail++; $display("FAIL flush_count got=%0d want=0", a_count); end
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b want=0", a_out_valid); end
    n_tests++; if (a_out_data !== 24'h000000) begin n_fail++; $display("FAIL flush_out_data got=%h want=000000", a_out_data); end
    a_in_valid = 1; a_in_data = 24'h777777; tick();
    a_in_valid = 0;
    n_tests++; if (a_out_data !== 24'h777777) begin n_fail++; $display("FAIL flush_next_data got=%h want=777777", a_out_data); end
    a_out_ready = 1; tick(); tick(); a_out_ready = 0;
    n_tests++; if (a_obs.size() !== 1) begin n_fail++; $display("FAIL flush_words got=%0d want=1", a_obs.size()); end
    while (a_obs.size() > 0 && a_ref.size() > 0) begin
      o = a_obs.pop_front(); r = a_ref.pop_front();
      n_tests++; if (o !== r || o === 24'hBEEF00) begin n_fail++; $display("FAIL flush_order got=%h want=%h", o, r); end
    end
  endtask

  task automatic test_boundaries;
    logic [23:0] o, r;
    a_idle();
    a_in_valid = 1; a_in_data = 24'hD00001; tick();
    a_in_data = 24'hD00002; tick();
    // Full: pop and offered push together; only the pop happens.
    a_in_data = 24'hD00003; a_out_ready = 1;
    n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got=%b want=0", a_in_ready); end
    tick();
    n_tests++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL full_pop_only_count got=%0d want=1", a_count); end
    n_tests++; if (a_out_data !== 24'hD00002) begin n_fail++; $display("FAIL full_pop_head got=%h want=d00002", a_out_data); end
    tick();  // D00003 is taken now, D00002 popped
    a_in_valid = 0;
    n_tests++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL full_next_count got=%0d want=1", a_count); end
    n_tests++; if (a_out_data !== 24'hD00003) begin n_fail++; $display("FAIL full_next_head got=%h want=d00003", a_out_data); end
    tick();
    // Empty: push with out_ready high; no bypass.
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL empty_out_valid got=%b want=0", a_out_valid); end
    a_in_valid = 1; a_in_data = 24'hD00004;
    tick();
    a_in_valid = 0; a_out_ready = 0;
    n_tests++; if (a_count !== 2'd1) begin n_fail++; $display("FAIL empty_push_count got=%0d want=1", a_count); end
    n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 24'hD00004) begin n_fail++; $display("FAIL empty_push_head got=%b/%h want=1/d00004", a_out_valid, a_out_data); end
    a_out_ready = 1; tick(); a_out_ready = 0;
    n_tests++; if (a_obs.size() !== 4) begin n_fail++; $display("FAIL bound_words got=%0d want=4", a_obs.size()); end
    while (a_obs.size() > 0 && a_ref.size() > 0) begin
      o = a_obs.pop_front(); r = a_ref.pop_front();
      n_tests++; if (o !== r) begin n_fail++; $display("FAIL bound_order got=%h want=%h", o, r); end
    end
  endtask

  initial begin
    test_reset();
    test_fill_backpressure();
    test_streaming();
    test_wrap_depth3();
    test_flush_priority();
    test_boundaries();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/elastic_pipe_buffer.md
# elastic_pipe_buffer

Parametrised pipeline buffer for the processor datapath, successor to the single resettable/enabled register. It holds up to DEPTH words of WIDTH bits in arrival order behind a valid/ready handshake on each side, so a producer stage and a consumer stage can stall independently without losing or duplicating data. It adds a synchronous flush for branch/hazard squashes and reports its occupancy.

## Interface
- WIDTH, 24, data word width in bits (≥1)
- DEPTH, 2, number of storage entries (≥1, any integer, not only powers of two)
- CW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden)

- clk  input  1  single clock, all state updates on its rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- flush  input  1  synchronous squash; empties the buffer at the next edge
- in_valid  input  1  producer presents in_data this cycle
- in_ready  output  1  buffer accepts a word this cycle
- in_data  input  WIDTH  word from producer
- out_valid  output  1  out_data holds the oldest stored word
- out_ready  input  1  consumer takes out_data this cycle
- out_data  output  WIDTH  oldest stored word; 0 when empty
- count  output  CW  number of stored words, 0..DEPTH

## Operation
- Storage is a circular array of DEPTH entries with a write pointer, a read pointer and a count register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH); it depends only on registered state, never on out_ready.
- out_valid = (count != 0); out_data = entry[rd_ptr] when out_valid, else all zeros.
- On push: entry[wr_ptr] ← in_data; wr_ptr advances.
- On pop: rd_ptr advances.
- Pointers wrap from DEPTH-1 to 0. With DEPTH=1, both pointers stay at 0.
- count update: push only → +1; pop only → −1; push and pop together → unchanged, and both pointers advance.
- Simultaneous push and pop are legal whenever 0 < count < DEPTH.
  - When full, in_ready=0, so a same-cycle pop frees the slot only for the next cycle.
  - When empty, out_valid=0, so there is no bypass and the pushed word appears on the next cycle.
- flush=1 at an edge: count ← 0 and wr_ptr ← rd_ptr ← 0. Any push or pop in that cycle is discarded; flush has priority. Storage contents may stay stale but are never visible, because out_data is gated to 0 when empty.
- reset=1 (asynchronous):
  - count, wr_ptr and rd_ptr go to 0.
  - All entries are cleared to 0.
  - Outputs immediately become in_ready=1, out_valid=0, out_data=0, count=0.
  - Release is sampled on the next rising edge; a word pushed in the first cycle after release is accepted.
  - Reset asserted mid-operation discards all held words; no partial update.
- No word is ever duplicated, dropped (outside flush/reset) or reordered.

## Timing
- Latency in to out is 1 cycle: a word pushed at edge N is visible on out_data/out_valid after edge N, if the buffer was empty.
- Throughput is 1 word/cycle sustained when DEPTH≥2, with out_ready held high.
- DEPTH=1 gives half rate (alternating full/empty), because there is no same-cycle refill when full.
- All outputs are functions of registers only (rd_ptr-indexed read plus zero gate); there is no combinational input-to-output path.
- count reflects state after the last edge and is valid in the same cycle as out_valid/in_ready.

## Test plan
- Reset/idle
  - Stimulus: assert reset asynchronously mid-cycle with 2 words stored (WIDTH=24, DEPTH=2).
  - Required response: immediately count=0, out_valid=0, out_data=0x000000, in_ready=1.
- Fill and backpressure
  - Stimulus: out_ready=0; push 0xA00001, 0xA00002, then offer 0xA00003.
  - Required response: count goes 1, then 2; in_ready=0 after the second push; 0xA00003 is not accepted; out_data=0xA00001.
- Streaming
  - Stimulus: DEPTH=2, in_valid=1 and out_ready=1 continuously; input 0x000001..0x000010.
  - Required response: out_data presents the same sequence, one per cycle, starting 1 cycle after the first push; count stays 1.
- Wrap-around with non-power-of-two depth
  - Stimulus: DEPTH=3; interleave pushes and pops for 10 words in a random-stall pattern.
  - Required response: output order matches input order, count never exceeds 3, and pointers wrap 2→0.
- Flush priority
  - Stimulus: count=2; in the same cycle assert flush=1, in_valid=1 (0xBEEF00) and out_ready=1.
  - Required response: next cycle count=0, out_valid=0, out_data=0; 0xBEEF00 is absent from all later output.
- Simultaneous push/pop at the boundaries
  - Stimulus: at count=DEPTH with out_ready=1, drive in_valid=1.
  - Required response: only the pop occurs; the pushed word is taken on the next cycle. At count=0 with in_valid=1 and out_ready=1, only the push occurs and out_valid rises the next cycle.
